// File: rtl/ps2_keyboard_receiver.sv
// PS/2 device-to-host frame receiver with scan-code set 2 prefix decoding (E0 extended, F0 break).
// Oversamples the slow PS/2 clock on Fast_Clock and presents each completed non-prefix scan code.
module ps2_keyboard_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       Fast_Clock,
  input  logic       Reset,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  output logic [7:0] Kb_Byte,
  output logic       Kb_Valid,
  output logic       Kb_Break,
  output logic       Kb_Extended,
  output logic       Frame_Error
);

  localparam int FC_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic [1:0]      r_clk_sync;
  logic [1:0]      r_data_sync;
  logic            r_filt_clk;
  logic            r_filt_d;
  logic [FC_W-1:0] r_filt_cnt;
  state_t          r_state;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_ext_pend;
  logic            r_brk_pend;
  logic [7:0]      r_kb_byte;
  logic            r_kb_valid;
  logic            r_kb_break;
  logic            r_kb_ext;
  logic            r_frame_err;

  logic   w_clk_s;
  logic   w_data_s;
  logic   w_strobe;
  logic   w_timeout;
  state_t w_state_nx;
  logic   w_start;
  logic   w_shift_en;
  logic   w_par_en;
  logic   w_accept;
  logic   w_err;

  assign w_clk_s   = r_clk_sync[1];
  assign w_data_s  = r_data_sync[1];
  assign w_strobe  = r_filt_d & ~r_filt_clk;
  assign w_timeout = (r_state != IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

  // Pin conditioning: two-flop synchronizers, then a level filter that needs FILTER_LEN agreeing samples.
  // NOTE: every register below is assigned with <= so all flops see pre-edge values, like real hardware.
  always_ff @(posedge Fast_Clock) begin
    if (!Reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_filt_clk  <= 1'b1;
      r_filt_d    <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], PS2_Clk};
      r_data_sync <= {r_data_sync[0], PS2_Data};
      r_filt_d    <= r_filt_clk;
      if (w_clk_s == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FC_W'(FILTER_LEN - 1)) begin
        r_filt_clk <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned (no latches).
  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_shift_en = 1'b0;
    w_par_en   = 1'b0;
    w_accept   = 1'b0;
    w_err      = 1'b0;
    if (w_strobe) begin
      case (r_state)
        IDLE: begin
          if (!w_data_s) begin
            w_state_nx = DATA;
            w_start    = 1'b1;
          end
        end
        DATA: begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nx = PARITY;
        end
        PARITY: begin
          w_par_en   = 1'b1;
          w_state_nx = STOP;
        end
        STOP: begin
          w_state_nx = IDLE;
          if (w_data_s && (^{r_shift, r_parity})) w_accept = 1'b1;
          else                                    w_err    = 1'b1;
        end
        default: w_state_nx = IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nx = IDLE;
      w_err      = 1'b1;
    end
  end

  always_ff @(posedge Fast_Clock) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_to_cnt    <= '0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
      r_kb_byte   <= 8'h00;
      r_kb_valid  <= 1'b0;
      r_kb_break  <= 1'b0;
      r_kb_ext    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_kb_valid  <= 1'b0;
      r_frame_err <= w_err;

      if (w_start)         r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 1'b1;

      if (w_shift_en) r_shift  <= {w_data_s, r_shift[7:1]};
      if (w_par_en)   r_parity <= w_data_s;

      if (w_strobe || r_state == IDLE) r_to_cnt <= '0;
      else                             r_to_cnt <= r_to_cnt + 1'b1;

      if (w_err) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (w_accept) begin
        case (r_shift)
          8'hE0: r_ext_pend <= 1'b1;
          8'hF0: r_brk_pend <= 1'b1;
          default: begin
            r_kb_byte  <= r_shift;
            r_kb_break <= r_brk_pend;
            r_kb_ext   <= r_ext_pend;
            r_kb_valid <= 1'b1;
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Kb_Byte     = r_kb_byte;
  assign Kb_Valid    = r_kb_valid;
  assign Kb_Break    = r_kb_break;
  assign Kb_Extended = r_kb_ext;
  assign Frame_Error = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Self-checking bench: a keyboard model drives PS/2 frames and pushes expected events;
// a negedge monitor pops and compares them whenever the receiver pulses an output.
module tb_ps2_keyboard_receiver;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 500;
  localparam int HALF       = 20;
  localparam int GAP        = 40;

  logic       Fast_Clock = 1'b0;
  logic       Reset      = 1'b0;
  logic       PS2_Clk    = 1'b1;
  logic       PS2_Data   = 1'b1;
  logic [7:0] Kb_Byte;
  logic       Kb_Valid;
  logic       Kb_Break;
  logic       Kb_Extended;
  logic       Frame_Error;

  ps2_keyboard_receiver #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .Fast_Clock (Fast_Clock),
    .Reset      (Reset),
    .PS2_Clk    (PS2_Clk),
    .PS2_Data   (PS2_Data),
    .Kb_Byte    (Kb_Byte),
    .Kb_Valid   (Kb_Valid),
    .Kb_Break   (Kb_Break),
    .Kb_Extended(Kb_Extended),
    .Frame_Error(Frame_Error)
  );

  always #5 Fast_Clock = ~Fast_Clock;

  typedef struct {
    logic [7:0] byte_v;
    logic       brk;
    logic       ext;
    logic       err;
    int         exp_cyc;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         mon_en   = 1'b0;
  logic [7:0] m_last   = 8'h00;
  logic       m_brk    = 1'b0;
  logic       m_ext    = 1'b0;

  always @(posedge Fast_Clock) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Fast_Clock);
  endtask

  // Reference model of the prefix decoder, evaluated at the stop-bit falling edge.
  task automatic model_stop(input logic [7:0] d, input bit bad, input int t_fall);
    exp_t e;
    if (bad) begin
      e = '{byte_v: m_last, brk: 1'b0, ext: 1'b0, err: 1'b1, exp_cyc: t_fall + FILTER_LEN + 3};
      q.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (d == 8'hE0) begin
      m_ext = 1'b1;
    end else if (d == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      e = '{byte_v: d, brk: m_brk, ext: m_ext, err: 1'b0, exp_cyc: t_fall + FILTER_LEN + 3};
      q.push_back(e);
      m_last = d;
      m_brk  = 1'b0;
      m_ext  = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit bad_stop,
                            input bit glitch);
    logic [10:0] bits;
    bits = {~bad_stop, (~^d) ^ flip_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      PS2_Data = bits[i];
      if (glitch && i >= 1 && i <= 8) begin
        wait_cyc(5);
        PS2_Clk = 1'b0;
        wait_cyc(4);
        PS2_Clk = 1'b1;
        wait_cyc(HALF - 9);
      end else begin
        wait_cyc(HALF);
      end
      if (i == 10) model_stop(d, flip_par || bad_stop, cyc);
      PS2_Clk = 1'b0;
      wait_cyc(HALF);
      PS2_Clk = 1'b1;
    end
    PS2_Data = 1'b1;
    wait_cyc(GAP);
  endtask

  // Start bit plus the first n data bits, leaving the clock high.
  task automatic send_partial(input logic [7:0] d, input int n);
    for (int i = 0; i <= n; i++) begin
      PS2_Data = (i == 0) ? 1'b0 : d[i-1];
      wait_cyc(HALF);
      PS2_Clk = 1'b0;
      wait_cyc(HALF);
      PS2_Clk = 1'b1;
    end
  endtask

  always @(negedge Fast_Clock) begin
    exp_t e;
    if (mon_en && (Kb_Valid || Frame_Error)) begin
      check("valid_error_exclusive", 32'(Kb_Valid & Frame_Error), 0);
      if (q.size() == 0) begin
        check("unexpected_pulse", {30'd0, Kb_Valid, Frame_Error}, 0);
      end else begin
        e = q.pop_front();
        check("kb_valid", 32'(Kb_Valid), 32'(!e.err));
        check("frame_error", 32'(Frame_Error), 32'(e.err));
        check("kb_byte", 32'(Kb_Byte), 32'(e.byte_v));
        if (!e.err) begin
          check("kb_break", 32'(Kb_Break), 32'(e.brk));
          check("kb_extended", 32'(Kb_Extended), 32'(e.ext));
        end
        if (e.exp_cyc > 0) check("pulse_latency", cyc, e.exp_cyc);
      end
    end
  end

  initial begin
    exp_t       e;
    logic [7:0] d;
    int         w;

    // Reset held low while the pins toggle: all outputs stay zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge Fast_Clock);
      PS2_Clk  = (i < 4) ? i[0] : 1'b1;
      PS2_Data = (i < 4) ? ~i[0] : 1'b1;
      check("reset_outputs", {19'd0, Kb_Byte, Kb_Valid, Kb_Break, Kb_Extended, Frame_Error}, 0);
    end
    PS2_Clk  = 1'b1;
    PS2_Data = 1'b1;
    wait_cyc(2);
    Reset  = 1'b1;
    mon_en = 1'b1;
    wait_cyc(GAP);

    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'h6B, 0, 0, 0);

    // Parity and stop-bit errors leave Kb_Byte untouched.
    send_frame(8'h1C, 1, 0, 0);
    send_frame(8'h1C, 0, 1, 0);

    // Timeout mid-frame after a break prefix: the prefix is dropped.
    send_frame(8'hF0, 0, 0, 0);
    send_partial(8'h1C, 4);
    e = '{byte_v: m_last, brk: 1'b0, ext: 1'b0, err: 1'b1, exp_cyc: 0};
    q.push_back(e);
    m_brk = 1'b0;
    m_ext = 1'b0;
    PS2_Data = 1'b1;
    wait_cyc(TIMEOUT + 10);
    wait_cyc(GAP);
    send_frame(8'h1C, 0, 0, 0);

    // Short glitches on the clock line must not create strobes.
    send_frame(8'h1C, 0, 0, 1);

    // Reset in the middle of bit 4 abandons the frame and clears the outputs.
    d = 8'h1C;
    send_partial(d, 3);
    PS2_Data = d[4];
    wait_cyc(5);
    Reset = 1'b0;
    wait_cyc(3);
    check("mid_reset_outputs", {19'd0, Kb_Byte, Kb_Valid, Kb_Break, Kb_Extended, Frame_Error}, 0);
    Reset    = 1'b1;
    m_last   = 8'h00;
    m_brk    = 1'b0;
    m_ext    = 1'b0;
    PS2_Data = 1'b1;
    wait_cyc(GAP);
    send_frame(8'h32, 0, 0, 0);

    w = 0;
    while (q.size() != 0 && w < 1000) begin
      wait_cyc(1);
      w++;
    end
    check("scoreboard_drained", q.size(), 0);
    check("kb_byte_final", 32'(Kb_Byte), 32'h32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
